// File: rtl/skolem_exhaustive_checker_if.sv
// Bus between the exhaustive Skolem checker and its environment
// (controller plus the external Skolem and formula blocks).
interface skolem_exhaustive_checker_if #(
  parameter int NUM_UNIV = 4,
  parameter int CNT_W    = NUM_UNIV + 1
);
  logic                start;
  logic [NUM_UNIV-1:0] univ_out;
  logic                exist_out;
  logic                sk_in;
  logic                phi_in;
  logic                busy;
  logic                done;
  logic                pass;
  logic [CNT_W-1:0]    fail_count;
  logic [CNT_W-1:0]    unreal_count;
  logic                first_fail_valid;
  logic [NUM_UNIV-1:0] first_fail_idx;

  modport master (
    output start, sk_in, phi_in,
    input  univ_out, exist_out, busy, done, pass, fail_count, unreal_count,
           first_fail_valid, first_fail_idx
  );

  modport slave (
    input  start, sk_in, phi_in,
    output univ_out, exist_out, busy, done, pass, fail_count, unreal_count,
           first_fail_valid, first_fail_idx
  );
endinterface

// File: rtl/skolem_exhaustive_checker.sv
// Enumerates every universal assignment x and checks
// (exists y. phi(x,y)) -> phi(x, f(x)) against an external Skolem block.
module skolem_exhaustive_checker #(
  parameter int NUM_UNIV = 4,
  parameter int CNT_W    = NUM_UNIV + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  skolem_exhaustive_checker_if.slave    bus
);
  typedef enum logic [2:0] {IDLE, P0, P1, PS, CHK, DONE} state_t;

  state_t              state, state_nxt;
  logic [NUM_UNIV-1:0] idx;
  logic                phi0, phi1, phis;
  logic [CNT_W-1:0]    fail_count, unreal_count, fail_nxt;
  logic                pass_r, ff_valid;
  logic [NUM_UNIV-1:0] ff_idx;
  logic                last, sat, violation;

  assign last      = (idx == '1);
  assign sat       = phi0 | phi1;
  assign violation = sat & ~phis;
  assign fail_nxt  = (violation && fail_count != '1) ? fail_count + CNT_W'(1) : fail_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = P0;
      P0:      state_nxt = P1;
      P1:      state_nxt = PS;
      PS:      state_nxt = CHK;
      CHK:     state_nxt = last ? DONE : P0;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // sk_in depends only on univ_out, so the PS pass-through forms no loop.
  always_comb begin
    bus.exist_out = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    case (state)
      P0:      bus.busy = 1'b1;
      P1:      begin bus.busy = 1'b1; bus.exist_out = 1'b1; end
      PS:      begin bus.busy = 1'b1; bus.exist_out = bus.sk_in; end
      CHK:     bus.busy = 1'b1;
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx          <= '0;
      phi0         <= 1'b0;
      phi1         <= 1'b0;
      phis         <= 1'b0;
      fail_count   <= '0;
      unreal_count <= '0;
      pass_r       <= 1'b0;
      ff_valid     <= 1'b0;
      ff_idx       <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          idx          <= '0;
          fail_count   <= '0;
          unreal_count <= '0;
          pass_r       <= 1'b0;
          ff_valid     <= 1'b0;
          ff_idx       <= '0;
        end
        P0: phi0 <= bus.phi_in;
        P1: phi1 <= bus.phi_in;
        PS: phis <= bus.phi_in;
        CHK: begin
          fail_count <= fail_nxt;
          if (!sat && unreal_count != '1) unreal_count <= unreal_count + CNT_W'(1);
          if (violation && !ff_valid) begin
            ff_valid <= 1'b1;
            ff_idx   <= idx;
          end
          // pass is registered on entry to DONE so it is valid alongside done.
          if (last) pass_r <= (fail_nxt == '0);
          else      idx    <= idx + NUM_UNIV'(1);
        end
        DONE: idx <= '0;
        default: ;
      endcase
    end
  end

  assign bus.univ_out         = idx;
  assign bus.fail_count       = fail_count;
  assign bus.unreal_count     = unreal_count;
  assign bus.pass             = pass_r;
  assign bus.first_fail_valid = ff_valid;
  assign bus.first_fail_idx   = ff_idx;
endmodule

// File: tb/tb_skolem_exhaustive_checker.sv
// Directed bench for skolem_exhaustive_checker with behavioural phi/Skolem
// models selectable per run.
module tb_skolem_exhaustive_checker;
  localparam int NU = 4;
  localparam int CW = NU + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   mode = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  skolem_exhaustive_checker_if #(.NUM_UNIV(NU), .CNT_W(CW)) bus ();

  skolem_exhaustive_checker #(.NUM_UNIV(NU), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // 0: phi=(y==x0^x1), f=x0^x1   1: same phi, f=x0   2: phi=y&~x3, f=1
  // 3: phi=~y, f=1 (every x fails)   4: phi=0 (every x unrealizable)
  function automatic logic sk_model(input int m, input logic [NU-1:0] x);
    case (m)
      0:       return x[0] ^ x[1];
      1:       return x[0];
      2, 3:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic phi_model(input int m, input logic [NU-1:0] x, input logic y);
    case (m)
      0, 1:    return y == (x[0] ^ x[1]);
      2:       return y & ~x[3];
      3:       return ~y;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    bus.sk_in  = sk_model(mode, bus.univ_out);
    bus.phi_in = phi_model(mode, bus.univ_out, bus.exist_out);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic longint all_outs();
    return {bus.univ_out, bus.exist_out, bus.busy, bus.done, bus.pass, bus.fail_count,
            bus.unreal_count, bus.first_fail_valid, bus.first_fail_idx};
  endfunction

  // Starts a run; observes after each edge E+k. lat = k at which done is seen.
  task automatic run(input int m, input int restart_at, input int abort_at,
                     output int lat, output int busy_n, output int proto_err);
    logic [NU-1:0] x;
    logic          ey;
    mode = m; lat = -1; busy_n = 0; proto_err = 0;
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (bus.done) begin lat = k; break; end
      if (bus.busy) busy_n++;
      if (k < 64) begin
        x  = NU'(k / 4);
        ey = (k % 4 == 1) ? 1'b1 : (k % 4 == 2) ? sk_model(m, x) : 1'b0;
        if (bus.univ_out !== x || bus.exist_out !== ey) proto_err++;
      end
      if (k == abort_at) begin
        rst = 1'b1; #1;
        chk("abort_outputs_zero", all_outs(), 0);
        @(negedge clk); rst = 1'b0;
        lat = -2;
        return;
      end
      bus.start = (k == restart_at);
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
  endtask

  typedef struct {
    int     m;
    logic   pass;
    int     fails;
    int     unreal;
    logic   ffv;
    int     ffi;
  } vec_t;

  vec_t vecs[6];
  int   lat, busy_n, perr, done_seen;

  initial begin
    vecs[0] = '{0, 1'b1, 0,  0,  1'b0, 0};
    vecs[1] = '{1, 1'b0, 8,  0,  1'b1, 2};
    vecs[2] = '{0, 1'b1, 0,  0,  1'b0, 0};
    vecs[3] = '{2, 1'b1, 0,  8,  1'b0, 0};
    vecs[4] = '{3, 1'b0, 16, 0,  1'b1, 0};
    vecs[5] = '{4, 1'b1, 0,  16, 1'b0, 0};

    bus.start = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("reset_outputs_zero", all_outs(), 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1 chk("idle_outputs_zero", all_outs(), 0);

    foreach (vecs[i]) begin
      run(vecs[i].m, -1, -1, lat, busy_n, perr);
      chk($sformatf("v%0d_done_latency", i), lat, 64);
      chk($sformatf("v%0d_busy_cycles", i), busy_n, 64);
      chk($sformatf("v%0d_protocol_errs", i), perr, 0);
      chk($sformatf("v%0d_pass", i), bus.pass, vecs[i].pass);
      chk($sformatf("v%0d_fail_count", i), bus.fail_count, vecs[i].fails);
      chk($sformatf("v%0d_unreal_count", i), bus.unreal_count, vecs[i].unreal);
      chk($sformatf("v%0d_ff_valid", i), bus.first_fail_valid, vecs[i].ffv);
      if (vecs[i].ffv) chk($sformatf("v%0d_ff_idx", i), bus.first_fail_idx, vecs[i].ffi);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_one_cycle", i), bus.done, 0);
      chk($sformatf("v%0d_results_held", i),
          {bus.pass, bus.fail_count, bus.unreal_count},
          {vecs[i].pass, CW'(vecs[i].fails), CW'(vecs[i].unreal)});
      repeat (2) @(posedge clk);
    end

    // Start mid-run and start during DONE must both be ignored.
    run(0, 10, -1, lat, busy_n, perr);
    chk("restart_done_latency", lat, 64);
    chk("restart_protocol_errs", perr, 0);
    chk("restart_pass", bus.pass, 1);
    bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    chk("start_in_done_ignored", bus.busy, 0);
    @(posedge clk); #1 chk("start_in_done_still_idle", bus.busy, 0);

    // Reset at cycle 30 of a failing run, then a clean rerun.
    run(1, -1, 30, lat, busy_n, perr);
    done_seen = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) done_seen++;
    end
    chk("abort_no_done_or_busy", done_seen, 0);
    chk("abort_results_cleared", all_outs(), 0);
    run(1, -1, -1, lat, busy_n, perr);
    chk("post_abort_latency", lat, 64);
    chk("post_abort_fail_count", bus.fail_count, 8);
    chk("post_abort_ff_idx", bus.first_fail_idx, 2);
    chk("post_abort_pass", bus.pass, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
